// File: rtl/placar_pkg.sv
// placar_pkg: mode/screen encodings and anode polarity shared by the scoreboard display scan.
package placar_pkg;
  typedef enum logic [1:0] {
    MODO_AUTO    = 2'b00,
    MODO_PLACAR  = 2'b01,
    MODO_CRONO   = 2'b10,
    MODO_APAGADO = 2'b11
  } modo_t;
  typedef enum logic {
    TELA_PLACAR = 1'b0,
    TELA_CRONO  = 1'b1
  } tela_t;
  localparam logic ANODO_OFF = 1'b1;
endpackage

// File: rtl/contador_tick.sv
// contador_tick: modulo-N counter with enable, sync clear and a one-cycle wrap pulse.
module contador_tick #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  logic [W-1:0] r_cnt;
  assign o_wrap = i_en && !i_clr && (r_cnt == W'(N - 1));
  assign o_cnt  = r_cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else r_cnt <= (i_clr || o_wrap) ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/varredura_display_placar.sv
// varredura_display_placar: multiplexed scan of a common-anode 7-segment bank,
// alternating between score and timer screens with its own prescaler.
module varredura_display_placar
  import placar_pkg::*;
#(
  parameter int NUM_DIGITOS   = 4,
  parameter int DIGITOS_CRONO = 2,
  parameter int OFFSET_CRONO  = 1,
  parameter int DIV_VARREDURA = 50000,
  parameter int TICKS_ALTERNA = 2000,
  parameter int BLANK_CICLOS  = 2,
  localparam int IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [1:0]                 modo,
  input  logic [4*NUM_DIGITOS-1:0]   placar_bcd,
  input  logic [4*DIGITOS_CRONO-1:0] crono_bcd,
  output logic [NUM_DIGITOS-1:0]     anodo,
  output logic [3:0]                 bcd_out,
  output logic                       tela,
  output logic [IW-1:0]              digito_idx
);
  localparam int PW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
  localparam int AW = (TICKS_ALTERNA > 1) ? $clog2(TICKS_ALTERNA) : 1;
  localparam logic [IW-1:0] PRIM_CRONO = IW'(OFFSET_CRONO);
  localparam logic [IW-1:0] ULT_CRONO  = IW'(OFFSET_CRONO + DIGITOS_CRONO - 1);
  localparam logic [IW-1:0] ULT_PLACAR = IW'(NUM_DIGITOS - 1);
  localparam logic [NUM_DIGITOS-1:0] UM = NUM_DIGITOS'(1);

  if (OFFSET_CRONO + DIGITOS_CRONO > NUM_DIGITOS) begin : g_chk_crono
    $error("timer digits exceed the physical bank");
  end
  if (BLANK_CICLOS >= DIV_VARREDURA) begin : g_chk_blank
    $error("blank window must be shorter than a slot");
  end

  modo_t                  r_modo;
  tela_t                  r_tela, w_tela_nxt, w_alvo;
  logic [IW-1:0]          r_idx, w_idx_nxt, w_idx_avanca, w_idx_crono;
  logic [NUM_DIGITOS-1:0] r_anodo, w_anodo_nxt;
  logic [3:0]             r_bcd, w_bcd_nxt;
  logic [PW-1:0]          w_presc;
  logic [AW-1:0]          w_alt_unused;
  logic                   w_tick, w_alt_wrap, w_mudou;

  assign w_mudou = r_modo != modo_t'(modo);

  contador_tick #(.N(DIV_VARREDURA)) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .i_en   (1'b1),
    .i_clr  (w_mudou),
    .o_cnt  (w_presc),
    .o_wrap (w_tick)
  );

  // Clearing on a mode change also suppresses a coincident wrap, so the mode change wins.
  contador_tick #(.N(TICKS_ALTERNA)) u_alternancia (
    .clock  (clock),
    .reset_n(reset_n),
    .i_en   (w_tick && r_modo == MODO_AUTO),
    .i_clr  (w_mudou || r_modo != MODO_AUTO),
    .o_cnt  (w_alt_unused),
    .o_wrap (w_alt_wrap)
  );

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_modo  <= MODO_AUTO;
      r_tela  <= TELA_PLACAR;
      r_idx   <= '0;
      r_anodo <= {NUM_DIGITOS{ANODO_OFF}};
      r_bcd   <= '0;
    end else begin
      r_modo  <= modo_t'(modo);
      r_tela  <= w_tela_nxt;
      r_idx   <= w_idx_nxt;
      r_anodo <= w_anodo_nxt;
      r_bcd   <= w_bcd_nxt;
    end

  always_comb begin
    w_alvo       = (modo_t'(modo) == MODO_CRONO) ? TELA_CRONO : TELA_PLACAR;
    w_idx_avanca = (r_tela == TELA_CRONO) ? ((r_idx == ULT_CRONO) ? PRIM_CRONO : r_idx + 1'b1)
                                          : ((r_idx == ULT_PLACAR) ? '0 : r_idx + 1'b1);
    w_tela_nxt   = w_mudou ? w_alvo : w_alt_wrap ? tela_t'(~r_tela) : r_tela;
    w_idx_nxt    = (w_mudou || w_alt_wrap) ? ((w_tela_nxt == TELA_CRONO) ? PRIM_CRONO : '0)
                 : w_tick ? w_idx_avanca : r_idx;
  end

  // The blank window is read straight off the prescaler count, which restarts every slot.
  always_comb begin
    w_idx_crono = r_idx - PRIM_CRONO;
    w_anodo_nxt = (r_modo == MODO_APAGADO || w_presc < PW'(BLANK_CICLOS))
                ? {NUM_DIGITOS{ANODO_OFF}} : ~(UM << r_idx);
    w_bcd_nxt   = (r_tela == TELA_CRONO) ? 4'(crono_bcd >> {w_idx_crono, 2'b00})
                                         : 4'(placar_bcd >> {r_idx, 2'b00});
  end

  assign anodo      = r_anodo;
  assign bcd_out    = r_bcd;
  assign tela       = r_tela;
  assign digito_idx = r_idx;
endmodule

// File: doc/varredura_display_placar.md
Name: varredura_display_placar

Overview:
- Parametrised multiplexed-scan controller for the scoreboard's common-anode 7-segment bank.
- Owns its own prescaler, so it no longer depends on external 120 Hz/60 Hz/2 s clock dividers.
- Cycles through NUM_DIGITOS digits, alternating automatically between the score screen and the timer screen, or holding one screen / blanking by mode.
- Drives the active-low anode lines and the BCD nibble that feeds the downstream BCD-to-7-segment decoder.

Parameters:
- NUM_DIGITOS, 4: physical digits in the bank.
- DIGITOS_CRONO, 2: digits used by the timer screen.
- OFFSET_CRONO, 1: index of the first physical digit used by the timer.
- DIV_VARREDURA, 50000: clock cycles per digit slot (1 kHz at 50 MHz).
- TICKS_ALTERNA, 2000: digit slots per screen in auto mode (2 s).
- BLANK_CICLOS, 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be less than DIV_VARREDURA.

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- modo, in, 2: 00 auto-alternate, 01 score only, 10 timer only, 11 blank.
- placar_bcd, in, 4*NUM_DIGITOS: score digits; nibble i belongs to physical digit i.
- crono_bcd, in, 4*DIGITOS_CRONO: timer digits; nibble j shown on physical digit OFFSET_CRONO+j.
- anodo, out, NUM_DIGITOS: digit enables, active-low; bit i is physical digit i.
- bcd_out, out, 4: nibble for the currently enabled digit.
- tela, out, 1: screen shown; 0 = score, 1 = timer.
- digito_idx, out, clog2(NUM_DIGITOS): physical digit currently scanned.

Behaviour:
- Reset (async, reset_n=0):
  - anodo = all 1s; bcd_out = 0; tela = 0; digito_idx = 0.
  - Prescaler, blank counter and alternation counter = 0.
- Prescaler:
  - Counts 0..DIV_VARREDURA-1, then wraps.
  - The wrap cycle is a slot tick; it is asserted for one cycle.
- Digit advance on each slot tick:
  - Score screen: digito_idx steps 0, 1, ..., NUM_DIGITOS-1, then wraps to 0.
  - Timer screen: steps OFFSET_CRONO .. OFFSET_CRONO+DIGITOS_CRONO-1, then wraps to OFFSET_CRONO.
  - The digits outside the timer range stay dark.
- Alternation counter (modo=00 only):
  - Counts slot ticks 0..TICKS_ALTERNA-1.
  - On the tick that wraps it, tela toggles and digito_idx loads the first digit of the new screen instead of advancing.
  - The counter is held at 0 when modo≠00.
- Screen per mode:
  - 01 forces tela=0; 10 forces tela=1.
  - 11 keeps scanning but holds anodo all 1s.
- Mode change:
  - modo is registered once. A change is detected when the registered value differs from the input; this takes one cycle.
  - On that cycle: prescaler, blank counter and alternation counter clear, and digito_idx loads the first digit of the target screen.
  - In auto mode the target screen is score (tela=0).
- Outputs:
  - anodo and bcd_out are registered and follow digito_idx with 1-cycle latency.
  - During the first BLANK_CICLOS cycles of every slot, anodo = all 1s while bcd_out already holds the new nibble.
  - Outside the blank window, anodo has only bit digito_idx low.
  - Score screen: bcd_out = placar_bcd[4*idx +: 4]. Timer screen: bcd_out = crono_bcd[4*(idx-OFFSET_CRONO) +: 4].
- Data sampling: placar_bcd and crono_bcd are sampled every cycle; no handshake is required.
- Simultaneous events: if a mode change and an alternation wrap land on the same cycle, the mode change wins.
- Static checks (elaboration-time assertions): OFFSET_CRONO+DIGITOS_CRONO ≤ NUM_DIGITOS; BLANK_CICLOS < DIV_VARREDURA.

Decomposition:
- Shared package placar_pkg holds:
  - The modo encodings MODO_AUTO, MODO_PLACAR, MODO_CRONO, MODO_APAGADO.
  - The tela encodings TELA_PLACAR, TELA_CRONO.
  - The anode-off constant.
- One sub-module: contador_tick.
  - A parametrised modulo-N counter with enable, synchronous clear and a one-cycle wrap pulse.
  - Instantiated twice: once as the prescaler, once as the alternation counter.

Test Plan:
Bench parameters: DIV_VARREDURA=4, TICKS_ALTERNA=8, BLANK_CICLOS=1, NUM_DIGITOS=4, DIGITOS_CRONO=2, OFFSET_CRONO=1.
1. Reset: hold reset_n=0 with clock running -> anodo=1111, bcd_out=0, tela=0, digito_idx=0. Release reset -> after the first slot tick, digito_idx=1.
2. Score scan: modo=01, placar_bcd=0x4321 -> per slot, anodo is 1111 for 1 cycle, then xxx0 with bcd_out=1, then digit 1 with bcd_out=2, digit 2 with 3, digit 3 with 4, then wraps to digit 0. Only one anode is ever low.
3. Timer scan: modo=10, crono_bcd=0x59 -> only digits 1 and 2 are scanned (anodo 1101 with bcd_out=9, then 1011 with bcd_out=5); digits 0 and 3 never go low; tela=1.
4. Auto alternation: modo=00 -> tela toggles every 8 slots (32 cycles). After each toggle digito_idx restarts at 0 (score) or 1 (timer).
5. Blank and mode change: modo=11 -> anodo stays 1111 while digito_idx keeps advancing. Switching modo 11→01 mid-slot -> one cycle later digito_idx=0 and the prescaler is cleared.
6. Async reset mid-slot with modo=00 and tela=1 -> outputs return to reset values in the same cycle, without waiting for a clock edge.
